// File: rtl/log_op_pipe.sv
// Two-stage pipelined evaluator of logical/reduction operators on three operands,
// with a per-burst running AND of results and a saturating count of true results.
module log_op_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_res,
    output logic             out_acc,
    output logic [CNT_W-1:0] true_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic             r_s1_acc_en;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_c;

    logic             r_out_valid;
    logic             r_out_res;
    logic             r_out_acc;
    logic             r_acc_state;
    logic [CNT_W-1:0] r_true_cnt;

    logic             w_s2_take;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_a_t;
    logic             w_b_t;
    logic             w_c_t;
    logic             w_res;
    logic             w_acc;
    logic             w_cnt_sat;

    // Handshake: a transfer happens on a side when valid && ready are both high at
    // the rising edge; valid never depends on ready, and a held output (out_valid,
    // out_res, out_acc) stays stable until taken. in_ready is combinational from
    // out_ready because there is no skid buffer.
    assign w_s2_take  = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_take;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign w_a_t = |r_s1_a;
    assign w_b_t = |r_s1_b;
    assign w_c_t = |r_s1_c;

    always_comb begin
        w_res = 1'b0;
        case (r_s1_op)
            3'd0:    w_res = w_a_t && w_b_t;
            3'd1:    w_res = w_a_t || w_b_t;
            3'd2:    w_res = !w_a_t;
            3'd3:    w_res = (r_s1_a == r_s1_b);
            3'd4:    w_res = (w_a_t && w_b_t) || w_c_t;
            3'd5:    w_res = ^r_s1_a;
            3'd6:    w_res = &r_s1_a;
            3'd7:    w_res = (r_s1_a != r_s1_b) && w_c_t;
            default: w_res = 1'b0;
        endcase
    end

    // A new burst (acc_en=0) restarts the running AND from this result alone.
    assign w_acc     = r_s1_acc_en ? (r_acc_state & w_res) : w_res;
    assign w_cnt_sat = (r_true_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_acc_en <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_c      <= '0;
        end else if (w_in_fire) begin
            r_s1_valid  <= 1'b1;
            r_s1_op     <= op;
            r_s1_acc_en <= acc_en;
            r_s1_a      <= a;
            r_s1_b      <= b;
            r_s1_c      <= c;
        end else if (w_s2_take) begin
            r_s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= 1'b0;
            r_out_acc   <= 1'b0;
            r_acc_state <= 1'b0;
        end else if (w_s2_take) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_res   <= w_res;
                r_out_acc   <= w_acc;
                r_acc_state <= w_acc;
            end
        end
    end

    // Clear wins over a coincident counted transfer; the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_true_cnt <= '0;
        end else if (cnt_clr) begin
            r_true_cnt <= '0;
        end else if (w_out_fire && r_out_res && !w_cnt_sat) begin
            r_true_cnt <= r_true_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_acc   = r_out_acc;
    assign true_cnt  = r_true_cnt;
    assign cnt_sat   = w_cnt_sat;

endmodule
